// File: rtl/sha1_ctrl.sv
// SHA-1 block controller: sequences LOAD / 80 ROUND / ACCUM / DONE and
// produces the message schedule W_t, K_t and round-function select.
module sha1_ctrl #(
    parameter int unsigned BlockWidth = 512,
    parameter int unsigned Rounds     = 80
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BlockWidth-1:0] block_i,
    input  logic                  start_i,
    input  logic                  init_i,
    input  logic                  digest_ack_i,
    output logic                  hold_o,
    output logic                  idle_o,
    output logic                  init_hash_o,
    output logic                  load_o,
    output logic                  round_en_o,
    output logic [6:0]            round_o,
    output logic [31:0]           w_o,
    output logic [31:0]           k_o,
    output logic [1:0]            func_sel_o,
    output logic                  accum_o,
    output logic                  digest_valid_o,
    output logic                  start_ignored_o
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StRound = 3'd2;
    localparam logic [2:0] StAccum = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [6:0] LastRound = 7'(Rounds - 1);

    logic [2:0]  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        init_q, init_d;
    logic        ign_q, ign_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_next;

    // Next schedule word W[t+16] from the 16-word sliding window.
    always_comb begin
        logic [31:0] x;
        x      = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
        w_next = {x[30:0], x[31]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        ign_d   = start_i && (state_q != StIdle);
        for (int unsigned i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        win_d[i] = block_i[32*(15-i) +: 32];
                    end
                    init_d  = init_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StRound;
            end
            StRound: begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_next;
                if (cnt_q == LastRound) begin
                    cnt_d   = '0;
                    state_d = StAccum;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StAccum: begin
                state_d = StDone;
            end
            StDone: begin
                if (digest_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            ign_q   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            ign_q   <= ign_d;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    always_comb begin
        hold_o          = (state_q != StIdle);
        idle_o          = (state_q == StIdle);
        load_o          = 1'b0;
        init_hash_o     = 1'b0;
        round_en_o      = 1'b0;
        round_o         = '0;
        w_o             = '0;
        k_o             = '0;
        func_sel_o      = '0;
        accum_o         = (state_q == StAccum);
        digest_valid_o  = (state_q == StDone);
        start_ignored_o = ign_q;

        if (state_q == StLoad) begin
            load_o      = 1'b1;
            init_hash_o = init_q;
        end

        if (state_q == StRound) begin
            round_en_o = 1'b1;
            round_o    = cnt_q;
            w_o        = win_q[0];
            if (cnt_q < 7'd20) begin
                k_o        = 32'h5A827999;
                func_sel_o = 2'd0;
            end else if (cnt_q < 7'd40) begin
                k_o        = 32'h6ED9EBA1;
                func_sel_o = 2'd1;
            end else if (cnt_q < 7'd60) begin
                k_o        = 32'h8F1BBCDC;
                func_sel_o = 2'd2;
            end else begin
                k_o        = 32'hCA62C1D6;
                func_sel_o = 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_sha1_ctrl.sv
// Randomized self-checking bench for sha1_ctrl against a behavioural schedule/timing model.
module tb_sha1_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [511:0] block_i;
    logic         start_i, init_i, digest_ack_i;
    logic         hold_o, idle_o, init_hash_o, load_o, round_en_o;
    logic [6:0]   round_o;
    logic [31:0]  w_o, k_o;
    logic [1:0]   func_sel_o;
    logic         accum_o, digest_valid_o, start_ignored_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] wm [80];

    sha1_ctrl #(.BlockWidth(512), .Rounds(80)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .block_i(block_i), .start_i(start_i),
        .init_i(init_i), .digest_ack_i(digest_ack_i), .hold_o(hold_o), .idle_o(idle_o),
        .init_hash_o(init_hash_o), .load_o(load_o), .round_en_o(round_en_o),
        .round_o(round_o), .w_o(w_o), .k_o(k_o), .func_sel_o(func_sel_o),
        .accum_o(accum_o), .digest_valid_o(digest_valid_o),
        .start_ignored_o(start_ignored_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Textbook schedule: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
    function automatic void build_sched(input logic [511:0] b);
        for (int t = 0; t < 16; t++) wm[t] = b[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            logic [31:0] x;
            x = wm[t-3] ^ wm[t-8] ^ wm[t-14] ^ wm[t-16];
            wm[t] = {x[30:0], x[31]};
        end
    endfunction

    function automatic logic [31:0] k_of(input int t);
        case (t / 20)
            0:       return 32'h5A827999;
            1:       return 32'h6ED9EBA1;
            2:       return 32'h8F1BBCDC;
            default: return 32'hCA62C1D6;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idle"}, 64'(idle_o), 64'd1);
        chk({tag, "_rest"}, 64'({hold_o, init_hash_o, load_o, round_en_o, round_o, w_o,
                                  k_o, func_sel_o, accum_o, digest_valid_o,
                                  start_ignored_o}), 64'd0);
    endtask

    task automatic run_block(input logic [511:0] b, input bit init, input int ign_t,
                             input int rst_t, input int ack_dly, input bit start_in_done,
                             input bit start_with_ack, input bit ack_noise);
        build_sched(b);
        chk("pre_idle", 64'(idle_o), 64'd1);
        chk("pre_hold", 64'(hold_o), 64'd0);
        block_i = b; init_i = init; start_i = 1'b1;
        step();
        start_i = 1'b0;
        block_i = {16{$urandom()}};
        init_i  = ~init;
        chk("load", 64'(load_o), 64'd1);
        chk("init_hash", 64'(init_hash_o), 64'(init));
        chk("load_hold", 64'(hold_o), 64'd1);
        chk("load_idle", 64'(idle_o), 64'd0);
        chk("load_ren", 64'(round_en_o), 64'd0);
        step();
        for (int t = 0; t < 80; t++) begin
            chk($sformatf("ren_t%0d", t), 64'(round_en_o), 64'd1);
            chk($sformatf("round_t%0d", t), 64'(round_o), 64'(t));
            chk($sformatf("w_t%0d", t), 64'(w_o), 64'(wm[t]));
            chk($sformatf("k_t%0d", t), 64'(k_o), 64'(k_of(t)));
            chk($sformatf("fsel_t%0d", t), 64'(func_sel_o), 64'(t / 20));
            chk($sformatf("misc_t%0d", t),
                64'({hold_o, idle_o, load_o, init_hash_o, accum_o, digest_valid_o}),
                64'(6'b100000));
            chk($sformatf("ign_t%0d", t), 64'(start_ignored_o),
                64'(ign_t >= 0 && t == ign_t + 1));
            if (t == rst_t) begin
                int bad = 0;
                rst_ni = 1'b0;
                #1;
                chk_reset_outputs("rst_mid");
                #1;
                rst_ni = 1'b1; start_i = 1'b0; digest_ack_i = 1'b0;
                for (int i = 0; i < 90; i++) begin
                    step();
                    if (accum_o || digest_valid_o || !idle_o) bad++;
                end
                chk("rst_no_digest", 64'(bad), 64'd0);
                return;
            end
            start_i      = (t == ign_t);
            digest_ack_i = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        start_i = 1'b0; digest_ack_i = 1'b0;
        chk("accum", 64'(accum_o), 64'd1);
        chk("accum_rest", 64'({round_en_o, round_o, w_o, k_o, func_sel_o, digest_valid_o,
                               load_o}), 64'd0);
        chk("accum_hold", 64'(hold_o), 64'd1);
        step();
        chk("dvalid", 64'(digest_valid_o), 64'd1);
        chk("done_accum", 64'(accum_o), 64'd0);
        for (int i = 0; i < ack_dly; i++) begin
            start_i = start_in_done && (i == 0);
            step();
            start_i = 1'b0;
            chk("wait_dvalid", 64'(digest_valid_o), 64'd1);
            chk("wait_hold", 64'(hold_o), 64'd1);
            chk("wait_idle", 64'(idle_o), 64'd0);
            chk("wait_ign", 64'(start_ignored_o), 64'(start_in_done && i == 0));
        end
        digest_ack_i = 1'b1; start_i = start_with_ack;
        step();
        digest_ack_i = 1'b0; start_i = 1'b0;
        chk("ack_idle", 64'(idle_o), 64'd1);
        chk("ack_dvalid", 64'(digest_valid_o), 64'd0);
        chk("ack_hold", 64'(hold_o), 64'd0);
        chk("ack_ign", 64'(start_ignored_o), 64'(start_with_ack));
        step();
        chk("post_ign", 64'(start_ignored_o), 64'd0);
        chk("post_idle", 64'(idle_o), 64'd1);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        logic [511:0] abc;
        rst_ni = 1'b0; start_i = 1'b0; init_i = 1'b0; digest_ack_i = 1'b0; block_i = '0;
        #1;
        chk_reset_outputs("por");
        #11;
        rst_ni = 1'b1;
        digest_ack_i = 1'b1;
        step();
        digest_ack_i = 1'b0;
        chk("ack_in_idle", 64'(idle_o), 64'd1);

        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        run_block(abc, 1'b1, 37, -1, 10, 1'b1, 1'b0, 1'b0);
        run_block(rand_block(), 1'b0, -1, -1, 2, 1'b0, 1'b1, 1'b1);
        run_block(rand_block(), 1'b1, -1, 50, 0, 1'b0, 1'b0, 1'b0);
        run_block(abc, 1'b1, -1, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            run_block(rand_block(), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 78)) : -1,
                      -1, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
